// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word, cache line, and the memory arbiter's
// state and grant encodings.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_data;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } lc3b_arb_state;

  typedef enum logic {
    arb_i,
    arb_d
  } lc3b_arb_grant;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the I-cache and D-cache onto one physical-memory port, one line
// transaction at a time, with round-robin resolution of simultaneous requests.
module mem_arbiter
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_read,
  input  logic [15:0]  i_address,
  output logic [127:0] i_rdata,
  output logic         i_resp,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [15:0]  d_address,
  input  logic [127:0] d_wdata,
  output logic [127:0] d_rdata,
  output logic         d_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  lc3b_arb_state state, next_state;
  lc3b_arb_grant grant, last_grant;
  logic          write_q;
  logic          i_req, d_req, take_d, grant_en;

  // Line offset bits never reach memory.
  logic unused_addr_lo;
  assign unused_addr_lo = ^{i_address[3:0], d_address[3:0]};

  always_comb begin
    i_req    = i_read;
    d_req    = d_read | d_write;
    take_d   = d_req && (!i_req || (last_grant == arb_i));
    grant_en = (state == IDLE) && (i_req || d_req);
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_en) next_state = BUSY;
      BUSY:    if (pmem_resp) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant        <= arb_i;
      last_grant   <= arb_i;
      write_q      <= 1'b0;
      pmem_address <= 16'h0000;
      pmem_wdata   <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
    end else begin
      if (grant_en) begin
        grant        <= take_d ? arb_d : arb_i;
        last_grant   <= take_d ? arb_d : arb_i;
        write_q      <= take_d && d_write;
        pmem_address <= take_d ? {d_address[15:4], 4'h0} : {i_address[15:4], 4'h0};
        pmem_wdata   <= d_wdata;
      end
      // Writes complete without touching the D-side read line.
      if ((state == BUSY) && pmem_resp) begin
        if (grant == arb_i)  i_rdata <= pmem_rdata;
        else if (!write_q)   d_rdata <= pmem_rdata;
      end
    end
  end

  assign pmem_read  = (state == BUSY) && !write_q;
  assign pmem_write = (state == BUSY) &&  write_q;
  assign i_resp     = (state == RESP) && (grant == arb_i);
  assign d_resp     = (state == RESP) && (grant == arb_d);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, checked against a transaction-level arbitration model.
module tb_mem_arbiter;
  import lc3b_types::*;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         i_read = 1'b0;
  logic [15:0]  i_address = '0;
  logic [127:0] i_rdata;
  logic         i_resp;
  logic         d_read = 1'b0;
  logic         d_write = 1'b0;
  logic [15:0]  d_address = '0;
  logic [127:0] d_wdata = '0;
  logic [127:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;

  int checks = 0;
  int errors = 0;

  bit           last_d;
  logic [127:0] exp_i, exp_d;

  mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_quiet(input string tag);
    chk({tag, "_resp"}, {i_resp, d_resp}, 0);
    chk({tag, "_strobe"}, {pmem_read, pmem_write}, 0);
    chk({tag, "_i_rdata"}, i_rdata, exp_i);
    chk({tag, "_d_rdata"}, d_rdata, exp_d);
  endtask

  // Called at a negedge in IDLE with the requests already driven.
  task automatic serve(input int lat, input logic [127:0] mdata);
    bit gd, wr;
    int n;
    logic [15:0]  ea;
    logic [127:0] ewd;
    if (i_read && (d_read || d_write)) gd = !last_d;
    else                               gd = d_read || d_write;
    wr  = gd && d_write;
    ea  = gd ? {d_address[15:4], 4'h0} : {i_address[15:4], 4'h0};
    ewd = d_wdata;
    n = 0;
    while (n < 6) begin
      @(negedge clk);
      n++;
      if (pmem_read || pmem_write) break;
    end
    chk("grant_latency", n, 1);
    chk("pmem_read", pmem_read, !wr);
    chk("pmem_write", pmem_write, wr);
    chk("pmem_address", pmem_address, ea);
    if (wr) chk("pmem_wdata", pmem_wdata, ewd);
    // The client's live inputs must no longer matter once granted.
    if (gd) begin
      d_address = 16'($urandom);
      d_wdata   = rnd128();
    end else begin
      i_address = 16'($urandom);
    end
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      chk("busy_strobe", {pmem_read, pmem_write}, {!wr, wr});
      chk("busy_address", pmem_address, ea);
      if (wr) chk("busy_wdata", pmem_wdata, ewd);
      chk("busy_no_resp", {i_resp, d_resp}, 0);
    end
    pmem_rdata = mdata;
    pmem_resp  = 1'b1;
    @(negedge clk);
    pmem_resp  = 1'b0;
    pmem_rdata = rnd128();
    if (!gd)     exp_i = mdata;
    else if (!wr) exp_d = mdata;
    last_d = gd;
    chk("i_resp", i_resp, !gd);
    chk("d_resp", d_resp, gd);
    chk("resp_strobe", {pmem_read, pmem_write}, 0);
    chk("i_rdata", i_rdata, exp_i);
    chk("d_rdata", d_rdata, exp_d);
    if (gd) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
    @(negedge clk);
    chk("resp_once", {i_resp, d_resp}, 0);
    chk("hold_i_rdata", i_rdata, exp_i);
    chk("hold_d_rdata", d_rdata, exp_d);
  endtask

  task automatic spurious();
    pmem_rdata = rnd128();
    pmem_resp  = 1'b1;
    @(negedge clk);
    pmem_resp  = 1'b0;
    check_quiet("spur1");
    @(negedge clk);
    check_quiet("spur2");
  endtask

  task automatic reset_mid_busy();
    i_read  = 1'b0;
    d_read  = 1'b0;
    d_write = 1'b0;
    @(negedge clk);
    i_address = 16'($urandom);
    i_read    = 1'b1;
    @(negedge clk);
    chk("rst_pre_busy", pmem_read, 1);
    #1 reset_n = 1'b0;
    #1;
    exp_i  = '0;
    exp_d  = '0;
    last_d = 1'b0;
    check_quiet("rst_async");
    chk("rst_address", pmem_address, 0);
    chk("rst_wdata", pmem_wdata, 0);
    i_read = 1'b0;
    @(negedge clk);
    reset_n    = 1'b1;
    pmem_rdata = rnd128();
    pmem_resp  = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    check_quiet("rst_stale1");
    @(negedge clk);
    check_quiet("rst_stale2");
  endtask

  initial begin
    int r;
    last_d = 1'b0;
    exp_i  = '0;
    exp_d  = '0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    chk("reset_address", pmem_address, 0);
    chk("reset_wdata", pmem_wdata, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check_quiet("post_reset");

    // Lone I read.
    i_address = 16'h1234;
    i_read    = 1'b1;
    serve(2, {16{8'hAA}});
    chk("lone_i_addr_line", exp_i, {16{8'hAA}});

    // Lone D write: d_rdata must stay as it was.
    d_address = 16'h4008;
    d_wdata   = {16{8'h55}};
    d_write   = 1'b1;
    serve(1, rnd128());

    spurious();
    reset_mid_busy();

    // Tie after reset: D first, then I.
    i_address = 16'h2222;
    d_address = 16'h3333;
    i_read    = 1'b1;
    d_read    = 1'b1;
    serve(0, rnd128());
    chk("tie_i_still_pending", i_read, 1);
    serve(1, rnd128());

    // Three consecutive ties: D, I, D.
    i_read = 1'b1;
    d_read = 1'b1;
    serve(1, rnd128());
    d_read = 1'b1;
    serve(0, rnd128());
    i_read = 1'b1;
    serve(2, rnd128());
    serve(0, rnd128());

    for (int it = 0; it < 60; it++) begin
      if (it == 30) reset_mid_busy();
      if (!i_read && !(d_read || d_write)) begin
        if ($urandom_range(0, 4) == 0) spurious();
        r = $urandom_range(1, 3);
        if (r[0]) begin
          i_address = 16'($urandom);
          i_read    = 1'b1;
        end
        if (r[1]) begin
          d_address = 16'($urandom);
          d_wdata   = rnd128();
          case ($urandom_range(0, 2))
            0:       begin d_read = 1'b1; d_write = 1'b0; end
            1:       begin d_read = 1'b0; d_write = 1'b1; end
            default: begin d_read = 1'b1; d_write = 1'b1; end
          endcase
        end
      end else if ($urandom_range(0, 1) == 1) begin
        if (!i_read) begin
          i_address = 16'($urandom);
          i_read    = 1'b1;
        end else if (!(d_read || d_write)) begin
          d_address = 16'($urandom);
          d_wdata   = rnd128();
          d_read    = 1'($urandom_range(0, 1));
          d_write   = !d_read;
        end
      end
      serve($urandom_range(0, 3), rnd128());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
